// File: rtl/sb_pattern_detector_pkg.sv
// Shared sideband definitions: the clock pattern constant and the detector state
// encoding. The local pattern generator uses the same constant.
package sb_pattern_detector_pkg;

  localparam logic [63:0] SB_CLK_PATTERN = {32{2'b10}};
  localparam logic [2:0]  MATCH_CNT_MAX  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } sb_det_state_e;

  function automatic logic is_clk_pattern(input logic [63:0] beat);
    return (beat == SB_CLK_PATTERN);
  endfunction

endpackage

// File: rtl/sb_pattern_detector.sv
// Sideband clock-pattern detector: waits for REQUIRED_MATCHES consecutive exact
// pattern beats while searching, or reports a timeout after TIMEOUT_CYCLES.
module sb_pattern_detector
  import sb_pattern_detector_pkg::*;
#(
  parameter int unsigned REQUIRED_MATCHES = 2,
  parameter int unsigned TIMEOUT_CYCLES   = 800
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start_detect,
  input  logic [63:0] i_deser_data,
  input  logic        i_deser_valid,
  output logic        o_pattern_samp_done,
  output logic        o_pattern_detected,
  output logic        o_detect_time_out,
  output logic [2:0]  o_match_cnt
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    MATCH_LAST = 3'(REQUIRED_MATCHES - 1);

  sb_det_state_e r_state;
  logic [CW-1:0] r_cyc_cnt;
  logic [2:0]    r_match_cnt;
  logic          r_samp_done;
  logic          r_detected;
  logic          r_time_out;

  logic          w_hit;
  logic [2:0]    w_match_inc;

  assign w_hit       = i_deser_valid && is_clk_pattern(i_deser_data);
  assign w_match_inc = (r_match_cnt == MATCH_CNT_MAX) ? MATCH_CNT_MAX : r_match_cnt + 3'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cyc_cnt   <= '0;
      r_match_cnt <= '0;
      r_samp_done <= 1'b0;
      r_detected  <= 1'b0;
      r_time_out  <= 1'b0;
    end else begin
      r_samp_done <= 1'b0;
      r_time_out  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cyc_cnt   <= '0;
          r_match_cnt <= '0;
          r_detected  <= 1'b0;
          if (i_start_detect) r_state <= ST_SEARCH;
        end
        ST_SEARCH: begin
          if (!i_start_detect) begin
            r_state     <= ST_IDLE;
            r_cyc_cnt   <= '0;
            r_match_cnt <= '0;
          end else if (w_hit && (r_match_cnt == MATCH_LAST)) begin
            // Detection takes priority over a timeout landing on the same cycle.
            r_state     <= ST_DONE;
            r_match_cnt <= w_match_inc;
            r_samp_done <= 1'b1;
            r_detected  <= 1'b1;
          end else if (r_cyc_cnt == CYC_LAST) begin
            r_state     <= ST_TIMEOUT;
            r_cyc_cnt   <= '0;
            r_match_cnt <= '0;
            r_time_out  <= 1'b1;
          end else begin
            r_cyc_cnt <= r_cyc_cnt + 1'b1;
            if (w_hit)              r_match_cnt <= w_match_inc;
            else if (i_deser_valid) r_match_cnt <= '0;
          end
        end
        ST_DONE: begin
          if (!i_start_detect) begin
            r_state     <= ST_IDLE;
            r_detected  <= 1'b0;
            r_match_cnt <= '0;
            r_cyc_cnt   <= '0;
          end
        end
        ST_TIMEOUT: begin
          // No automatic retry: the requester must drop and re-raise start.
          if (!i_start_detect) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_pattern_samp_done = r_samp_done;
  assign o_pattern_detected  = r_detected;
  assign o_detect_time_out   = r_time_out;
  assign o_match_cnt         = r_match_cnt;

endmodule

// File: tb/tb_sb_pattern_detector.sv
// Bench for sb_pattern_detector: directed vectors with literal expectations plus a
// per-cycle behavioural model feeding an expected-output queue.
module tb_sb_pattern_detector;

  localparam int REQ = 2;
  localparam int TMO = 800;
  localparam logic [63:0] PAT = 64'hAAAA_AAAA_AAAA_AAAA;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] data;
  logic        valid;
  logic        o_pattern_samp_done;
  logic        o_pattern_detected;
  logic        o_detect_time_out;
  logic [2:0]  o_match_cnt;

  sb_pattern_detector #(
    .REQUIRED_MATCHES(REQ),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_start_detect     (start),
    .i_deser_data       (data),
    .i_deser_valid      (valid),
    .o_pattern_samp_done(o_pattern_samp_done),
    .o_pattern_detected (o_pattern_detected),
    .o_detect_time_out  (o_detect_time_out),
    .o_match_cnt        (o_match_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  // Output vector layout: {samp_done, detected, time_out, match_cnt[2:0]}
  task automatic chk(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {o_pattern_samp_done, o_pattern_detected, o_detect_time_out, o_match_cnt};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got done/det/to/cnt=%b required %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 searching, 2 found, 3 gave up.
  int m_mode = 0;
  int m_elapsed = 0;
  int m_run = 0;
  bit m_det = 0;
  bit p_done, p_to, p_hit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_elapsed = 0; m_run = 0; m_det = 0;
      exp_q.delete();
    end else begin
      p_done = 0; p_to = 0;
      p_hit = valid && (data == PAT);
      if (m_mode == 0) begin
        if (start) begin m_mode = 1; m_elapsed = 0; m_run = 0; end
      end else if (m_mode == 1) begin
        if (!start) begin
          m_mode = 0; m_run = 0;
        end else begin
          if (p_hit) m_run = (m_run < 7) ? m_run + 1 : 7;
          else if (valid) m_run = 0;
          if (p_hit && m_run == REQ) begin
            m_mode = 2; p_done = 1; m_det = 1;
          end else if (m_elapsed == TMO - 1) begin
            m_mode = 3; p_to = 1; m_run = 0;
          end else begin
            m_elapsed++;
          end
        end
      end else if (m_mode == 2) begin
        if (!start) begin m_mode = 0; m_det = 0; m_run = 0; end
      end else begin
        if (!start) m_mode = 0;
      end
      exp_q.push_back({p_done, m_det, p_to, 3'(m_run)});
    end
  end

  // Scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) chk("cycle", exp_q.pop_front());
  end

  // Driver: one input cycle, then settle just after the sampling edge
  task automatic step(input logic v, input logic [63:0] d);
    @(negedge clk);
    valid = v;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] rd;
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; data = '0;
    #3;
    chk("reset", 6'b000_000);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Two consecutive matches
    start = 1'b1;
    step(1'b0, '0);   chk("t1_entry", 6'b000_000);
    step(1'b1, PAT);  chk("t1_m1",    6'b000_001);
    step(1'b1, PAT);  chk("t1_det",   6'b110_010);
    step(1'b0, '0);   chk("t1_hold",  6'b010_010);
    step(1'b1, PAT);  chk("t1_ign1",  6'b010_010);
    step(1'b1, '0);   chk("t1_ign2",  6'b010_010);
    start = 1'b0;
    step(1'b0, '0);   chk("t1_stop",  6'b000_000);

    // Broken run, hold on invalid, near-miss beat
    start = 1'b1;
    step(1'b0, '0);
    step(1'b1, PAT);      chk("t2_m1",    6'b000_001);
    step(1'b0, '0);       chk("t2_hold",  6'b000_001);
    step(1'b1, '0);       chk("t2_clr",   6'b000_000);
    step(1'b1, PAT);      chk("t2_m1b",   6'b000_001);
    step(1'b1, PAT ^ 64'h1); chk("t2_near", 6'b000_000);
    step(1'b1, PAT);      chk("t2_m1c",   6'b000_001);
    step(1'b1, PAT);      chk("t2_det",   6'b110_010);
    start = 1'b0;
    step(1'b0, '0);       chk("t2_stop",  6'b000_000);

    // Timeout after TMO search cycles
    start = 1'b1;
    step(1'b0, '0);
    for (int i = 0; i < TMO - 1; i++) begin
      rd = {$urandom, $urandom};
      if (rd == PAT) rd = '0;
      step(1'($urandom_range(0, 1)), rd);
    end
    chk("t3_pre", 6'b000_000);
    step(1'b0, '0);  chk("t3_to",    6'b001_000);
    step(1'b1, PAT); chk("t3_after", 6'b000_000);
    step(1'b1, PAT); chk("t3_noretry", 6'b000_000);
    start = 1'b0;
    step(1'b0, '0);  chk("t3_stop",  6'b000_000);

    // Detection on the last search cycle beats the timeout
    start = 1'b1;
    step(1'b0, '0);
    for (int i = 0; i < TMO - 2; i++) step(1'b0, '0);
    step(1'b1, PAT); chk("t4_m1",   6'b000_001);
    step(1'b1, PAT); chk("t4_det",  6'b110_010);
    step(1'b0, '0);  chk("t4_noto", 6'b010_010);
    start = 1'b0;
    step(1'b0, '0);  chk("t4_stop", 6'b000_000);

    // Abort after one match, restart needs two fresh matches
    start = 1'b1;
    step(1'b0, '0);
    step(1'b1, PAT); chk("t5_m1",    6'b000_001);
    start = 1'b0;
    step(1'b1, PAT); chk("t5_abort", 6'b000_000);
    start = 1'b1;
    step(1'b0, '0);  chk("t5_entry", 6'b000_000);
    step(1'b1, PAT); chk("t5_m1b",   6'b000_001);
    step(1'b1, PAT); chk("t5_det",   6'b110_010);

    // Asynchronous reset while found
    step(1'b0, '0);  chk("t6_done",  6'b010_010);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t6_async", 6'b000_000);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, PAT); chk("t6_idle1", 6'b000_000);
    step(1'b1, PAT); chk("t6_idle2", 6'b000_000);
    start = 1'b1;
    step(1'b0, '0);  chk("t6_entry", 6'b000_000);
    step(1'b1, PAT); chk("t6_m1",    6'b000_001);
    step(1'b1, PAT); chk("t6_det",   6'b110_010);
    start = 1'b0;
    step(1'b0, '0);  chk("t6_stop",  6'b000_000);
    step(1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
